// File: rtl/fetch_pc_unit_pkg.sv
// Shared widths, opcode patterns, condition codes and state encodings for the fetch PC stage.
// Decode helper classifies an instruction word into its branch kind.
package fetch_pc_unit_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [10:0] OP_BR    = 11'b11010110000;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_HS = 4'h2, CC_LO = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        BK_NONE  = 3'd0,
        BK_B     = 3'd1,
        BK_BCOND = 3'd2,
        BK_CBZ   = 3'd3,
        BK_CBNZ  = 3'd4,
        BK_BR    = 3'd5
    } br_kind_e;

    function automatic br_kind_e decode_kind(input logic [INSTR_LEN-1:0] instr);
        br_kind_e k;
        k = BK_NONE;
        if (instr[31:26] == OP_B)          k = BK_B;
        else if (instr[31:24] == OP_BCOND) k = BK_BCOND;
        else if (instr[31:24] == OP_CBZ)   k = BK_CBZ;
        else if (instr[31:24] == OP_CBNZ)  k = BK_CBNZ;
        else if (instr[31:21] == OP_BR)    k = BK_BR;
        return k;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_branch_cond_eval.sv
// Evaluates a 4-bit condition code against {N,Z,C,V}.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Odd codes are the complement of the even code below them, except 0xF which is always true.
module branch_cond_eval
    import fetch_pc_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;
    logic base;

    assign n = flags[3];
    assign z = flags[2];
    assign c = flags[1];
    assign v = flags[0];

    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
    end

    assign taken = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);

endmodule

// File: rtl/fetch_pc_unit.sv
// Holds the PC and sequences each instruction through FETCH then EXEC, resolving branches in EXEC.
// Latency: 2 cycles per retired instruction, plus 1 per stalled EXEC cycle.
// Backpressure: stall holds EXEC with pc frozen; halt parks the unit in HALT until reset.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic [3:0]           flags,
    input  logic [WORD-1:0]      rt_data,
    input  logic [WORD-1:0]      rn_data,
    input  logic                 stall,
    input  logic                 halt,
    output logic [WORD-1:0]      pc,
    output logic                 instr_valid,
    output logic                 branch_taken,
    output logic                 halted
);

    state_e          state;
    br_kind_e        br_kind;
    logic            cond_taken;
    logic            take;
    logic [WORD-1:0] pc_plus4;
    logic [WORD-1:0] off26;
    logic [WORD-1:0] off19;
    logic [WORD-1:0] target;
    logic [WORD-1:0] next_pc;

    branch_cond_eval u_cond (
        .cond  (instruction[3:0]),
        .flags (flags),
        .taken (cond_taken)
    );

    // Sign-extend then scale by 4; the low two zeros are the shift.
    assign off26    = {{(WORD-28){instruction[25]}}, instruction[25:0], 2'b00};
    assign off19    = {{(WORD-21){instruction[23]}}, instruction[23:5], 2'b00};
    assign pc_plus4 = pc + WORD'(4);

    always_comb begin
        br_kind = decode_kind(instruction);
        take    = 1'b0;
        target  = pc_plus4;
        case (br_kind)
            BK_B: begin
                take   = 1'b1;
                target = pc + off26;
            end
            BK_BCOND: begin
                take   = cond_taken;
                target = pc + off19;
            end
            BK_CBZ: begin
                take   = (rt_data == '0);
                target = pc + off19;
            end
            BK_CBNZ: begin
                take   = (rt_data != '0);
                target = pc + off19;
            end
            BK_BR: begin
                take   = 1'b1;
                target = rn_data;
            end
            default: begin
                take   = 1'b0;
                target = pc_plus4;
            end
        endcase
        next_pc = take ? target : pc_plus4;
    end

    assign instr_valid = (state == ST_EXEC) && !stall;
    // A branch whose target lands on pc+4 is indistinguishable from fall-through.
    assign branch_taken = instr_valid && (next_pc != pc_plus4);
    assign halted = (state == ST_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
        end else begin
            case (state)
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    if (!stall) begin
                        pc    <= next_pc;
                        state <= halt ? ST_HALT : ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
